// File: rtl/aoi_req_scheduler_pkg.sv
// aoi_sched_pkg: shared types, defaults and the round-robin pick function
package aoi_sched_pkg;
    localparam int NUM_REQ_DEF = 4;
    localparam int CNT_W_DEF = 16;

    typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;

    typedef struct packed {
        logic       found;
        logic [3:0] id;
    } pick_t;

    // Walk offsets from high to low so the smallest offset from ptr wins
    function automatic pick_t rr_pick(input logic [15:0] valid, input logic [3:0] ptr, input int n);
        pick_t p;
        int idx;
        p = '0;
        for (int k = 15; k >= 0; k--) begin
            if (k < n) begin
                idx = (int'(ptr) + k) % n;
                if (valid[idx]) begin
                    p.found = 1'b1;
                    p.id = 4'(idx);
                end
            end
        end
        return p;
    endfunction
endpackage

// File: rtl/aoi_req_scheduler_if.sv
// aoi_req_scheduler_if: request/response bundle between requesters, consumer and scheduler
interface aoi_req_scheduler_if #(
    parameter int NUM_REQ = aoi_sched_pkg::NUM_REQ_DEF
);
    localparam int ID_W = $clog2(NUM_REQ);
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [2*NUM_REQ-1:0] req_a;
    logic [2*NUM_REQ-1:0] req_b;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic                 rsp_o;
    logic [ID_W-1:0]      rsp_id;

    modport master (output req_valid, req_a, req_b, rsp_ready,
                    input  req_ready, rsp_valid, rsp_o, rsp_id);
    modport slave  (input  req_valid, req_a, req_b, rsp_ready,
                    output req_ready, rsp_valid, rsp_o, rsp_id);
endinterface

// File: rtl/aoi_req_scheduler_core.sv
// aoi_core: registered and-or-invert stage, updates only when en is high
module aoi_core (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic       o
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) o <= 1'b0;
        else if (en) o <= ~((a[1] & a[0]) | (b[1] & b[0]));
endmodule

// File: rtl/aoi_req_scheduler.sv
// aoi_req_scheduler: round-robin sharing of one registered AOI unit among NUM_REQ requesters.
// Optional per-requester grant counters when AOI_SCHED_GRANT_CNT_EN is defined.
module aoi_req_scheduler import aoi_sched_pkg::*; #(
    parameter int NUM_REQ = NUM_REQ_DEF
`ifdef AOI_SCHED_GRANT_CNT_EN
    , parameter int CNT_W = CNT_W_DEF
`endif
) (
    input  logic clk,
    input  logic rst_n,
    aoi_req_scheduler_if.slave bus,
`ifdef AOI_SCHED_GRANT_CNT_EN
    input  logic cnt_clr,
    output logic [NUM_REQ*CNT_W-1:0] grant_cnt,
`endif
    output logic busy
);
    localparam int ID_W = $clog2(NUM_REQ);

    state_t          state, next;
    pick_t           pick;
    logic            grant;
    logic [ID_W-1:0] win, rr_ptr, id_q;
    logic [1:0]      a_q, b_q;

    // rst_n gating keeps req_ready low while reset is held
    always_comb begin
        pick = rr_pick(16'(bus.req_valid), 4'(rr_ptr), NUM_REQ);
        win = ID_W'(pick.id);
        grant = rst_n && pick.found && (state == IDLE || (state == RESP && bus.rsp_ready));
        bus.req_ready = grant ? NUM_REQ'(1) << win : '0;
        next = state == IDLE ? (grant ? EVAL : IDLE) :
               state == EVAL ? RESP :
               !bus.rsp_ready ? RESP : grant ? EVAL : IDLE;
    end

    assign bus.rsp_valid = state == RESP;
    assign busy = state != IDLE;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= IDLE;
            rr_ptr <= '0;
            a_q <= '0;
            b_q <= '0;
            id_q <= '0;
            bus.rsp_id <= '0;
        end else begin
            state <= next;
            if (grant) begin
                rr_ptr <= (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
                a_q <= bus.req_a[2*win +: 2];
                b_q <= bus.req_b[2*win +: 2];
                id_q <= win;
            end
            if (state == EVAL) bus.rsp_id <= id_q;
        end

    aoi_core u_core (
        .clk(clk),
        .rst_n(rst_n),
        .en(state == EVAL),
        .a(a_q),
        .b(b_q),
        .o(bus.rsp_o)
    );

`ifdef AOI_SCHED_GRANT_CNT_EN
    logic [NUM_REQ-1:0][CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else if (cnt_clr) cnt <= '0;
        else
            for (int i = 0; i < NUM_REQ; i++)
                if (grant && int'(win) == i && cnt[i] != '1) cnt[i] <= cnt[i] + 1'b1;

    assign grant_cnt = cnt;
`endif
endmodule

// File: tb/tb_aoi_req_scheduler.sv
// tb_aoi_req_scheduler: directed stimulus with a response scoreboard and decoupled monitor.
module tb_aoi_req_scheduler;
    localparam int N = 4;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    always #5 clk = ~clk;

    aoi_req_scheduler_if #(.NUM_REQ(N)) bus();

`ifdef AOI_SCHED_GRANT_CNT_EN
    logic cnt_clr = 1'b0;
    logic [N*CW-1:0] grant_cnt;
`endif

    aoi_req_scheduler #(
        .NUM_REQ(N)
`ifdef AOI_SCHED_GRANT_CNT_EN
        , .CNT_W(CW)
`endif
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.slave),
`ifdef AOI_SCHED_GRANT_CNT_EN
        .cnt_clr(cnt_clr),
        .grant_cnt(grant_cnt),
`endif
        .busy(busy)
    );

    int n_chk = 0;
    int n_fail = 0;
    int sb[$];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // expected entry encoding: id*2 + o
    always @(negedge clk)
        if (bus.rsp_valid && bus.rsp_ready) begin
            if (sb.size() == 0) chk("rsp_unexpected", 1, 0);
            else begin
                int e;
                e = sb.pop_front();
                chk("rsp_id", int'(bus.rsp_id), e >> 1);
                chk("rsp_o", int'(bus.rsp_o), e & 1);
            end
        end

    task automatic single(input logic [1:0] a, input logic [1:0] b, input int o);
        bus.req_a[5:4] = a;
        bus.req_b[5:4] = b;
        bus.req_valid = 4'b0100;
        sb.push_back(2 * 2 + o);
        @(negedge clk);
        chk("t2_ready", int'(bus.req_ready), 4);
        cyc();
        bus.req_valid = '0;
        @(negedge clk);
        chk("t2_lat_n1", int'(bus.rsp_valid), 0);
        cyc();
        @(negedge clk);
        chk("t2_lat_n2", int'(bus.rsp_valid), 1);
        repeat (3) cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.req_valid = 4'hf;
        bus.req_a = 8'b00_01_00_11;
        bus.req_b = 8'b11_10_00_00;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("rst_rsp_valid", int'(bus.rsp_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_req_ready", int'(bus.req_ready), 0);
        chk("rst_rsp_o", int'(bus.rsp_o), 0);
        chk("rst_rsp_id", int'(bus.rsp_id), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // all four valid: grants 0,1,2,3,0 every other cycle
        sb.push_back(0); sb.push_back(3); sb.push_back(5); sb.push_back(6); sb.push_back(0);
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            chk("t1_ready", int'(bus.req_ready), (k % 2) ? 0 : 1 << ((k / 2) % 4));
            chk("t1_valid", int'(bus.rsp_valid), int'(k >= 2 && k % 2 == 0));
            cyc();
        end
        bus.req_valid = '0;
        repeat (3) cyc();

        single(2'b11, 2'b00, 0);
        single(2'b10, 2'b01, 1);

        // rr_ptr is 3: requester 3 beats requester 0
        bus.req_a = 8'b11_00_00_00;
        bus.req_b = 8'b11_00_00_01;
        bus.req_valid = 4'b1001;
        sb.push_back(6); sb.push_back(1);
        @(negedge clk);
        chk("t4_ready3", int'(bus.req_ready), 8);
        cyc();
        bus.req_valid = 4'b0001;
        @(negedge clk);
        chk("t4_eval_ready", int'(bus.req_ready), 0);
        cyc();
        @(negedge clk);
        chk("t4_ready0", int'(bus.req_ready), 1);
        cyc();
        bus.req_valid = '0;
        repeat (3) cyc();

        // backpressure with pending requests
        bus.rsp_ready = 1'b0;
        bus.req_valid = 4'b0010;
        sb.push_back(3);
        @(negedge clk);
        chk("t3_ready1", int'(bus.req_ready), 2);
        cyc();
        bus.req_valid = 4'b1001;
        sb.push_back(6); sb.push_back(1);
        @(negedge clk);
        chk("t3_eval_ready", int'(bus.req_ready), 0);
        cyc();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t3_hold_valid", int'(bus.rsp_valid), 1);
            chk("t3_hold_o", int'(bus.rsp_o), 1);
            chk("t3_hold_id", int'(bus.rsp_id), 1);
            chk("t3_hold_ready", int'(bus.req_ready), 0);
            cyc();
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("t3_release_ready", int'(bus.req_ready), 8);
        cyc();
        bus.req_valid = 4'b0001;
        @(negedge clk);
        chk("t3_eval2_ready", int'(bus.req_ready), 0);
        cyc();
        @(negedge clk);
        chk("t3_b2b_ready", int'(bus.req_ready), 1);
        cyc();
        bus.req_valid = '0;
        repeat (3) cyc();

        // reset in EVAL
        bus.req_valid = 4'b0100;
        @(negedge clk);
        chk("t5_ready_a", int'(bus.req_ready), 4);
        cyc();
        bus.req_valid = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("t5_eval_rsp_valid", int'(bus.rsp_valid), 0);
        chk("t5_eval_busy", int'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();

        // reset in RESP with the response held
        bus.rsp_ready = 1'b0;
        bus.req_valid = 4'b0100;
        @(negedge clk);
        chk("t5_ready_b", int'(bus.req_ready), 4);
        cyc();
        bus.req_valid = '0;
        cyc();
        @(negedge clk);
        chk("t5_pre_rsp_valid", int'(bus.rsp_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_resp_rsp_valid", int'(bus.rsp_valid), 0);
        chk("t5_resp_busy", int'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        cyc();
        bus.req_valid = 4'b1010;
        sb.push_back(3);
        @(negedge clk);
        chk("t5_first_grant", int'(bus.req_ready), 2);
        cyc();
        bus.req_valid = '0;
        repeat (3) cyc();

`ifdef AOI_SCHED_GRANT_CNT_EN
        cnt_clr = 1'b1;
        cyc();
        cnt_clr = 1'b0;
        bus.req_valid = 4'b0010;
        repeat (10) sb.push_back(3);
        repeat (19) cyc();
        bus.req_valid = '0;
        repeat (3) cyc();
        chk("cnt_ten", int'(grant_cnt[CW +: CW]), (10 < (1 << CW) - 1) ? 10 : (1 << CW) - 1);
        bus.req_valid = 4'b0010;
        cnt_clr = 1'b1;
        sb.push_back(3);
        @(negedge clk);
        chk("cnt_clr_ready", int'(bus.req_ready), 2);
        cyc();
        cnt_clr = 1'b0;
        bus.req_valid = '0;
        chk("cnt_cleared", int'(grant_cnt[CW +: CW]), 0);
        repeat (3) cyc();
`endif

        chk("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
